// File: rtl/sram_arbiter_pkg.sv
// Shared types and default widths for the two-master single-port SRAM arbiter.
package sram_arbiter_pkg;

   localparam int unsigned SRAM_ADDR_W = 32;
   localparam int unsigned SRAM_DATA_W = 32;

   // Which master owns the read response arriving on the next cycle
   typedef enum logic [1:0] {
      OWN_NONE    = 2'd0,
      OWN_INST    = 2'd1,
      OWN_DATA_RD = 2'd2
   } owner_e;

   typedef enum logic {
      GNT_INST = 1'b0,
      GNT_DATA = 1'b1
   } last_gnt_e;

endpackage

// File: rtl/sram_arb_pick.sv
// Two-input grant decision: fixed data priority, or round-robin when SRAM_ARB_RR_EN is defined.
module sram_arb_pick
   import sram_arbiter_pkg::*;
(
`ifdef SRAM_ARB_RR_EN
   input  logic clk,
`endif
   input  logic resetn,
   input  logic inst_req,
   input  logic data_req,
   output logic inst_gnt,
   output logic data_gnt
);

   logic inst_wins;

`ifdef SRAM_ARB_RR_EN
   last_gnt_e last_d, last_q;

   // On contention the master that lost the previous grant goes first
   always_comb begin
      inst_wins = inst_req & (~data_req | (last_q == GNT_DATA));
   end

   always_comb begin
      last_d = last_q;
      if (inst_gnt) begin
         last_d = GNT_INST;
      end else if (data_gnt) begin
         last_d = GNT_DATA;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_q <= GNT_INST;
      end else begin
         last_q <= last_d;
      end
   end
`else
   always_comb begin
      inst_wins = inst_req & ~data_req;
   end
`endif

   // Grants are combinational but forced low while reset is held
   always_comb begin
      inst_gnt = resetn & inst_wins;
      data_gnt = resetn & data_req & ~inst_wins;
   end

endmodule

// File: rtl/sram_arbiter.sv
// Zero-cycle-grant arbiter for a fetch port and a load-store port sharing one single-port SRAM.
// Build option: define SRAM_ARB_RR_EN for round-robin contention instead of data priority.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = SRAM_ADDR_W,
   parameter int unsigned DATA_W = SRAM_DATA_W
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                inst_req,
   input  logic [ADDR_W-1:0]   inst_addr,
   output logic                inst_gnt,
   output logic                inst_rvalid,
   output logic [DATA_W-1:0]   inst_rdata,
   input  logic                data_req,
   input  logic [DATA_W/8-1:0] data_we,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic                data_gnt,
   output logic                data_rvalid,
   output logic [DATA_W-1:0]   data_rdata,
   output logic                sram_en,
   output logic [DATA_W/8-1:0] sram_we,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic [DATA_W-1:0]   sram_wdata,
   input  logic [DATA_W-1:0]   sram_rdata
);

   owner_e owner_d, owner_q;

   sram_arb_pick u_pick (
`ifdef SRAM_ARB_RR_EN
      .clk      (clk),
`endif
      .resetn   (resetn),
      .inst_req (inst_req),
      .data_req (data_req),
      .inst_gnt (inst_gnt),
      .data_gnt (data_gnt)
   );

   always_comb begin
      sram_en    = inst_gnt | data_gnt;
      sram_we    = '0;
      sram_addr  = inst_addr;
      sram_wdata = data_wdata;
      owner_d    = OWN_NONE;
      if (data_gnt) begin
         sram_we   = data_we;
         sram_addr = data_addr;
         if (data_we == '0) begin
            owner_d = OWN_DATA_RD;
         end
      end else if (inst_gnt) begin
         owner_d = OWN_INST;
      end
   end

   // Owner is rewritten every cycle so an idle cycle never repeats a response
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         owner_q <= OWN_NONE;
      end else begin
         owner_q <= owner_d;
      end
   end

   always_comb begin
      inst_rvalid = (owner_q == OWN_INST);
      data_rvalid = (owner_q == OWN_DATA_RD);
      inst_rdata  = sram_rdata;
      data_rdata  = sram_rdata;
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter with a transaction-level grant/response/memory model.
module tb_sram_arbiter;

   logic        clk;
   logic        resetn;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_gnt;
   logic        inst_rvalid;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic [3:0]  data_we;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_gnt;
   logic        data_rvalid;
   logic [31:0] data_rdata;
   logic        sram_en;
   logic [3:0]  sram_we;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // model state
   logic [31:0] model_mem [16];
   bit          m_rv_inst, m_rv_data, m_last_data;
   logic [31:0] m_rdata;

   sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
      .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
      .data_rdata(data_rdata),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] init_word(int unsigned i);
      return 32'h5A00_0000 ^ (i * 32'h0101_0101);
   endfunction

   // 16-word SRAM with one-cycle read latency
   initial begin : sram_model
      logic [31:0] mem [16];
      for (int i = 0; i < 16; i++) mem[i] = init_word(i);
      sram_rdata = '0;
      forever begin
         @(posedge clk);
         if (sram_en) begin
            if (sram_we == 4'h0) begin
               sram_rdata <= mem[sram_addr[5:2]];
            end else begin
               for (int b = 0; b < 4; b++)
                  if (sram_we[b]) mem[sram_addr[5:2]][8*b +: 8] = sram_wdata[8*b +: 8];
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_rv_inst   = 1'b0;
      m_rv_data   = 1'b0;
      m_last_data = 1'b0;
   endtask

   // One clock cycle: check DUT against the model at negedge, then advance the model.
   task automatic cycle(output bit gi, output bit gd);
      bit ei, ed, inst_wins;
      @(negedge clk);
`ifdef SRAM_ARB_RR_EN
      inst_wins = m_last_data;
`else
      inst_wins = 1'b0;
`endif
      ei = inst_req && (!data_req || inst_wins);
      ed = data_req && !ei;
      chk("inst_gnt", inst_gnt, ei);
      chk("data_gnt", data_gnt, ed);
      chk("sram_en", sram_en, ei || ed);
      if (ei) begin
         chk("sram_addr_inst", sram_addr, inst_addr);
         chk("sram_we_inst", sram_we, 0);
      end else if (ed) begin
         chk("sram_addr_data", sram_addr, data_addr);
         chk("sram_we_data", sram_we, data_we);
         if (data_we != 4'h0) chk("sram_wdata", sram_wdata, data_wdata);
      end else begin
         chk("sram_we_idle", sram_we, 0);
      end
      chk("inst_rvalid", inst_rvalid, m_rv_inst);
      chk("data_rvalid", data_rvalid, m_rv_data);
      if (m_rv_inst) chk("inst_rdata", inst_rdata, m_rdata);
      if (m_rv_data) chk("data_rdata", data_rdata, m_rdata);
      chk("rdata_passthru", data_rdata, sram_rdata);

      m_rv_inst = ei;
      m_rv_data = ed && (data_we == 4'h0);
      if (ei) m_rdata = model_mem[inst_addr[5:2]];
      if (ed) begin
         if (data_we == 4'h0) begin
            m_rdata = model_mem[data_addr[5:2]];
         end else begin
            for (int b = 0; b < 4; b++)
               if (data_we[b]) model_mem[data_addr[5:2]][8*b +: 8] = data_wdata[8*b +: 8];
         end
      end
      if (ei) m_last_data = 1'b0;
      else if (ed) m_last_data = 1'b1;
      gi = ei;
      gd = ed;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn   = 1'b0;
      inst_req = 1'b0;
      data_req = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   initial begin : main
      bit gi, gd;
      logic [3:0] pat;
      for (int i = 0; i < 16; i++) model_mem[i] = init_word(i);
      model_reset();
      m_rdata    = '0;
      resetn     = 1'b0;
      inst_req   = 1'b1;
      inst_addr  = 32'h0;
      data_req   = 1'b1;
      data_we    = 4'h0;
      data_addr  = 32'h0;
      data_wdata = 32'h0;

      // outputs held low in reset even with both requests up
      #3;
      chk("rst_inst_gnt", inst_gnt, 0);
      chk("rst_data_gnt", data_gnt, 0);
      chk("rst_sram_en", sram_en, 0);
      chk("rst_rvalid", {inst_rvalid, data_rvalid}, 0);
      inst_req = 1'b0;
      data_req = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      resetn = 1'b1;

      // lone fetch, granted on the first edge after reset release
      inst_req  = 1'b1;
      inst_addr = 32'h1C00_0000;
      #1;
      chk("lit_inst_gnt", inst_gnt, 1);
      chk("lit_inst_en", sram_en, 1);
      chk("lit_inst_addr", sram_addr, 32'h1C00_0000);
      chk("lit_inst_we", sram_we, 0);
      cycle(gi, gd);
      inst_req = 1'b0;
      chk("lit_inst_rvalid", inst_rvalid, 1);
      chk("lit_inst_rdata", inst_rdata, 32'h5A00_0000);

      // data write
      data_req   = 1'b1;
      data_we    = 4'hF;
      data_addr  = 32'h100;
      data_wdata = 32'hDEAD_BEEF;
      #1;
      chk("lit_wr_gnt", data_gnt, 1);
      chk("lit_wr_we", sram_we, 4'hF);
      cycle(gi, gd);
      data_req = 1'b0;
      chk("lit_wr_rvalid", {inst_rvalid, data_rvalid}, 0);

      // back-to-back inst, data, inst reads
      inst_req  = 1'b1;
      inst_addr = 32'h4;
      cycle(gi, gd);
      inst_req  = 1'b0;
      data_req  = 1'b1;
      data_we   = 4'h0;
      data_addr = 32'h100;
      chk("lit_b2b0_v", {inst_rvalid, data_rvalid}, 2'b10);
      chk("lit_b2b0_d", inst_rdata, 32'h5B01_0101);
      cycle(gi, gd);
      data_req  = 1'b0;
      inst_req  = 1'b1;
      inst_addr = 32'hC;
      chk("lit_b2b1_v", {inst_rvalid, data_rvalid}, 2'b01);
      chk("lit_b2b1_d", data_rdata, 32'hDEAD_BEEF);
      cycle(gi, gd);
      inst_req = 1'b0;
      chk("lit_b2b2_v", {inst_rvalid, data_rvalid}, 2'b10);
      chk("lit_b2b2_d", inst_rdata, 32'h5903_0303);
      cycle(gi, gd);

      // contention for 4 cycles straight out of reset
      do_reset();
      inst_req  = 1'b1;
      inst_addr = 32'h8;
      data_req  = 1'b1;
      data_we   = 4'h0;
      data_addr = 32'h10;
      pat = '0;
      for (int k = 0; k < 4; k++) begin
         cycle(gi, gd);
         pat[k] = gd;
      end
`ifdef SRAM_ARB_RR_EN
      chk("lit_contend_pat", pat, 4'b0101);
`else
      chk("lit_contend_pat", pat, 4'b1111);
`endif
      inst_req = 1'b0;
      data_req = 1'b0;
      cycle(gi, gd);

      // async reset mid-cycle right after an inst grant
      inst_req  = 1'b1;
      inst_addr = 32'h14;
      #1;
      chk("lit_pre_rst_gnt", inst_gnt, 1);
      resetn = 1'b0;
      #1;
      chk("lit_async_gnt", inst_gnt, 0);
      chk("lit_async_en", sram_en, 0);
      inst_req = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      chk("lit_in_rst_rvalid", inst_rvalid, 0);
      resetn = 1'b1;
      #1;
      chk("lit_post_rst_rvalid", inst_rvalid, 0);
      cycle(gi, gd);

      // idle for 10 cycles
      for (int k = 0; k < 10; k++) begin
         cycle(gi, gd);
         chk("lit_idle", {sram_en, inst_rvalid, data_rvalid}, 0);
      end

      // randomized traffic; each requester holds its fields until granted
      for (int k = 0; k < 400; k++) begin
         cycle(gi, gd);
         if (!inst_req || gi) begin
            inst_req  = ($urandom_range(0, 99) < 60);
            inst_addr = $urandom;
         end
         if (!data_req || gd) begin
            data_req   = ($urandom_range(0, 99) < 60);
            data_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            data_addr  = $urandom;
            data_wdata = $urandom;
         end
      end
      inst_req = 1'b0;
      data_req = 1'b0;
      cycle(gi, gd);
      cycle(gi, gd);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
